// File: rtl/ecc_stream_decoder.sv
// Two-stage SEC-DED Hamming decoder on a valid/ready word stream, with
// saturating SEC/DED counters and a first-error log that raises irq.
module ecc_stream_decoder #(
   parameter int DWIDTH = 128,
   parameter int TWIDTH = 8,
   parameter int CNTW   = 16,
   localparam int SW    = $clog2(DWIDTH + $clog2(DWIDTH + 1) + 1),
   localparam int CW    = DWIDTH + SW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW-1:0]     in_cw,
   input  logic [TWIDTH-1:0] in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [TWIDTH-1:0] out_tag,
   output logic              out_sec,
   output logic              out_ded,
   input  logic              cfg_correct,
   input  logic              cnt_clr,
   output logic [CNTW-1:0]   sec_cnt,
   output logic [CNTW-1:0]   ded_cnt,
   input  logic              log_clr,
   output logic              log_valid,
   output logic [TWIDTH-1:0] log_tag,
   output logic [SW-1:0]     log_syn,
   output logic              log_ded,
   output logic              irq
);

   localparam logic [SW:0] CW_L = (SW + 1)'(CW);

   // Codeword index holding data bit i: the i-th index >= 3 that is not a power of two.
   function automatic int data_idx(input int i);
      int cnt;
      int idx;
      cnt = 0;
      idx = 0;
      for (int j = 3; j < i + 16; j++) begin
         if (idx == 0 && (j & (j - 1)) != 0) begin
            if (cnt == i) idx = j;
            cnt = cnt + 1;
         end
      end
      return idx;
   endfunction

   // Handshake: a word moves on a cycle where valid and ready are both high;
   // the producer holds valid and payload stable until that cycle.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic [SW-1:0] syn_c;
   logic          par_c;

   always_comb begin
      syn_c = '0;
      par_c = 1'b0;
      for (int j = 0; j < CW; j++) begin
         par_c = par_c ^ in_cw[j];
         for (int k = 0; k < SW; k++) begin
            if (((j >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ in_cw[j];
         end
      end
   end

   logic              s1_valid;
   logic [CW-1:0]     s1_cw;
   logic [TWIDTH-1:0] s1_tag;
   logic [SW-1:0]     s1_syn;
   logic              s1_par;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_tag   <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_cw    <= in_cw;
         s1_tag   <= in_tag;
         s1_syn   <= syn_c;
         s1_par   <= par_c;
      end
   end

   // Odd parity pointing past the codeword cannot be a single flip.
   logic syn_ok, sec_c, ded_c, fix;
   assign syn_ok = ({1'b0, s1_syn} < CW_L);
   assign sec_c  = s1_par && syn_ok;
   assign ded_c  = s1_par ? !syn_ok : (s1_syn != '0);
   assign fix    = sec_c && cfg_correct;

   logic [DWIDTH-1:0] data_c;
   for (genvar i = 0; i < DWIDTH; i++) begin : g_data
      localparam int IDX = data_idx(i);
      assign data_c[i] = s1_cw[IDX] ^ (fix && (s1_syn == SW'(IDX)));
   end

   // Parity and check bits carry no data once the syndrome is known.
   logic [SW:0] unused_bits;
   assign unused_bits[SW] = s1_cw[0];
   for (genvar k = 0; k < SW; k++) begin : g_unused
      assign unused_bits[k] = s1_cw[1 << k];
   end

   logic [SW-1:0] out_syn;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_syn   <= '0;
         out_sec   <= 1'b0;
         out_ded   <= 1'b0;
      end else if (en) begin
         out_valid <= s1_valid;
         out_data  <= data_c;
         out_tag   <= s1_tag;
         out_syn   <= s1_syn;
         out_sec   <= s1_valid && sec_c;
         out_ded   <= s1_valid && ded_c;
      end
   end

   logic hs;
   assign hs = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         sec_cnt <= '0;
         ded_cnt <= '0;
      end else begin
         if (hs && out_sec && !(&sec_cnt)) sec_cnt <= sec_cnt + 1'b1;
         if (hs && out_ded && !(&ded_cnt)) ded_cnt <= ded_cnt + 1'b1;
      end
   end

   // A clear arriving with a new error re-arms straight onto that error.
   always_ff @(posedge clk) begin
      if (rst) begin
         log_valid <= 1'b0;
         log_tag   <= '0;
         log_syn   <= '0;
         log_ded   <= 1'b0;
      end else if (hs && (out_sec || out_ded) && (!log_valid || log_clr)) begin
         log_valid <= 1'b1;
         log_tag   <= out_tag;
         log_syn   <= out_syn;
         log_ded   <= out_ded;
      end else if (log_clr) begin
         log_valid <= 1'b0;
      end
   end

   assign irq = log_valid;

endmodule
